// File: rtl/rca_config_table.sv
// Per-RCA register-mapping table: lookup for issue, in-flight tracking and config writes.
// Optional feature macro RCA_CFG_SHADOW_EN adds a shadow bank with a drain/swap activation FSM.
//
// state | meaning
// IDLE  | no activation pending; act_ready high
// DRAIN | waiting for in-flight uses of the latched RCA to reach zero
// SWAP  | copy shadow to active for the latched RCA; act_done high, cfg_ready low
module rca_config_table #(
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int MAX_INFLIGHT    = 4,
  localparam int RCA_W  = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int MAXP   = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS,
  localparam int PORT_W = (MAXP > 1) ? $clog2(MAXP) : 1,
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [RCA_W-1:0]             cfg_rca_sel,
  input  logic                         cfg_src_dest,
  input  logic [PORT_W-1:0]            cfg_port_sel,
  input  logic [4:0]                   cfg_reg_addr,
  output logic                         cfg_err,
  input  logic                         act_valid,
  output logic                         act_ready,
  input  logic [RCA_W-1:0]             act_rca_sel,
  output logic                         act_done,
  input  logic [RCA_W-1:0]             issue_rca_sel,
  input  logic                         issue_valid,
  output logic [NUM_READ_PORTS*5-1:0]  issue_src_addrs,
  output logic [NUM_WRITE_PORTS*5-1:0] issue_dest_addrs,
  output logic                         issue_blocked,
  input  logic                         done_valid,
  input  logic [RCA_W-1:0]             done_rca_sel
);

  logic [4:0]       act_src [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]       act_dst [NUM_RCAS][NUM_WRITE_PORTS];
  logic [CNT_W-1:0] cnt     [NUM_RCAS];
  logic [NUM_RCAS-1:0] inc, dec;
  logic [CNT_W-1:0] cnt_issue, cnt_cfg;
  logic cfg_rca_ok, cfg_port_ok, cfg_fire, cfg_wr;
  logic act_ok, act_fire, drain_block;

  assign cfg_rca_ok  = int'(cfg_rca_sel) < NUM_RCAS;
  assign cfg_port_ok = cfg_src_dest ? (int'(cfg_port_sel) < NUM_WRITE_PORTS)
                                    : (int'(cfg_port_sel) < NUM_READ_PORTS);
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign cfg_wr      = cfg_fire && cfg_rca_ok && cfg_port_ok;
  assign act_ok      = int'(act_rca_sel) < NUM_RCAS;
  assign act_fire    = act_valid && act_ready;

  // issue and done on the same RCA cancel; done at zero is ignored
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      inc[r] = issue_valid && (issue_rca_sel == RCA_W'(r));
      dec[r] = done_valid && (done_rca_sel == RCA_W'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RCAS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        if (inc[r] && !dec[r] && cnt[r] != CNT_W'(MAX_INFLIGHT)) cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    issue_src_addrs  = '0;
    issue_dest_addrs = '0;
    cnt_issue        = '0;
    cnt_cfg          = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      if (issue_rca_sel == RCA_W'(r)) begin
        cnt_issue = cnt[r];
        for (int p = 0; p < NUM_READ_PORTS; p++)  issue_src_addrs[p*5 +: 5]  = act_src[r][p];
        for (int p = 0; p < NUM_WRITE_PORTS; p++) issue_dest_addrs[p*5 +: 5] = act_dst[r][p];
      end
      if (cfg_rca_sel == RCA_W'(r)) cnt_cfg = cnt[r];
    end
  end

  assign issue_blocked = (cnt_issue == CNT_W'(MAX_INFLIGHT)) || drain_block;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= (cfg_fire && !(cfg_rca_ok && cfg_port_ok)) || (act_fire && !act_ok);
  end

`ifdef RCA_CFG_SHADOW_EN
  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;
  state_t           state, state_nx;
  logic [RCA_W-1:0] act_lat;
  logic [CNT_W-1:0] cnt_lat;
  logic [4:0]       shd_src [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]       shd_dst [NUM_RCAS][NUM_WRITE_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      act_lat <= '0;
    end else begin
      state <= state_nx;
      if (act_fire && act_ok) act_lat <= act_rca_sel;
    end
  end

  always_comb begin
    cnt_lat = '0;
    for (int r = 0; r < NUM_RCAS; r++)
      if (act_lat == RCA_W'(r)) cnt_lat = cnt[r];
  end

  always_comb begin
    state_nx  = state;
    act_ready = 1'b0;
    act_done  = 1'b0;
    cfg_ready = 1'b1;
    case (state)
      IDLE: begin
        act_ready = 1'b1;
        if (act_fire && act_ok) state_nx = DRAIN;
      end
      DRAIN: if (cnt_lat == '0) state_nx = SWAP;
      SWAP: begin
        act_done  = 1'b1;
        cfg_ready = 1'b0;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign drain_block = (state != IDLE) && (issue_rca_sel == act_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)  begin shd_src[r][p] <= '0; act_src[r][p] <= '0; end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin shd_dst[r][p] <= '0; act_dst[r][p] <= '0; end
      end
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
          if (cfg_wr && !cfg_src_dest && cfg_rca_sel == RCA_W'(r) && cfg_port_sel == PORT_W'(p))
            shd_src[r][p] <= cfg_reg_addr;
          if (state == SWAP && act_lat == RCA_W'(r)) act_src[r][p] <= shd_src[r][p];
        end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (cfg_wr && cfg_src_dest && cfg_rca_sel == RCA_W'(r) && cfg_port_sel == PORT_W'(p))
            shd_dst[r][p] <= cfg_reg_addr;
          if (state == SWAP && act_lat == RCA_W'(r)) act_dst[r][p] <= shd_dst[r][p];
        end
      end
    end
  end
`else
  // direct mode: writes hit the active map, so hold them off while the RCA has uses in flight
  assign cfg_ready   = (cnt_cfg == '0);
  assign act_ready   = 1'b1;
  assign drain_block = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_done <= 1'b0;
    else        act_done <= act_fire && act_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)  act_src[r][p] <= '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) act_dst[r][p] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)
          if (cfg_wr && !cfg_src_dest && cfg_rca_sel == RCA_W'(r) && cfg_port_sel == PORT_W'(p))
            act_src[r][p] <= cfg_reg_addr;
        for (int p = 0; p < NUM_WRITE_PORTS; p++)
          if (cfg_wr && cfg_src_dest && cfg_rca_sel == RCA_W'(r) && cfg_port_sel == PORT_W'(p))
            act_dst[r][p] <= cfg_reg_addr;
      end
    end
  end
`endif

  a_no_issue_when_blocked: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_valid && issue_blocked));

endmodule

// File: tb/tb_rca_config_table.sv
// Directed bench for rca_config_table; covers both builds selected by RCA_CFG_SHADOW_EN.
module tb_rca_config_table;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, cfg_src_dest, cfg_err;
  logic [1:0]  cfg_rca_sel;
  logic [2:0]  cfg_port_sel;
  logic [4:0]  cfg_reg_addr;
  logic        act_valid, act_ready, act_done;
  logic [1:0]  act_rca_sel;
  logic [1:0]  issue_rca_sel;
  logic        issue_valid, issue_blocked;
  logic [24:0] issue_src_addrs;
  logic [9:0]  issue_dest_addrs;
  logic        done_valid;
  logic [1:0]  done_rca_sel;

  int checks = 0;
  int errors = 0;

  rca_config_table dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rca_sel(cfg_rca_sel),
    .cfg_src_dest(cfg_src_dest), .cfg_port_sel(cfg_port_sel), .cfg_reg_addr(cfg_reg_addr),
    .cfg_err(cfg_err),
    .act_valid(act_valid), .act_ready(act_ready), .act_rca_sel(act_rca_sel), .act_done(act_done),
    .issue_rca_sel(issue_rca_sel), .issue_valid(issue_valid),
    .issue_src_addrs(issue_src_addrs), .issue_dest_addrs(issue_dest_addrs),
    .issue_blocked(issue_blocked),
    .done_valid(done_valid), .done_rca_sel(done_rca_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    cfg_valid = 0; cfg_rca_sel = 0; cfg_src_dest = 0; cfg_port_sel = 0; cfg_reg_addr = 0;
    act_valid = 0; act_rca_sel = 0; issue_valid = 0; issue_rca_sel = 0;
    done_valid = 0; done_rca_sel = 0;
  endtask

  task automatic look(input logic [1:0] r);
    issue_rca_sel = r;
    #1;
  endtask

  task automatic do_issue(input logic [1:0] r);
    issue_valid = 1; issue_rca_sel = r;
    cyc();
    issue_valid = 0;
  endtask

  task automatic do_done(input logic [1:0] r);
    done_valid = 1; done_rca_sel = r;
    cyc();
    done_valid = 0;
  endtask

  task automatic do_cfg(input logic [1:0] r, input logic sd, input logic [2:0] p, input logic [4:0] a);
    cfg_valid = 1; cfg_rca_sel = r; cfg_src_dest = sd; cfg_port_sel = p; cfg_reg_addr = a;
    cyc();
    cfg_valid = 0;
  endtask

  task automatic do_act(input logic [1:0] r);
    act_valid = 1; act_rca_sel = r;
    cyc();
    act_valid = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (3) cyc();
    rst_n = 1;
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_act_ready", act_ready, 1);
    chk("rst_act_done", act_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_blocked", issue_blocked, 0);
    chk("rst_src", issue_src_addrs, 0);
    chk("rst_dest", issue_dest_addrs, 0);
    cyc();

    // in-flight counter behaviour on RCA1
    do_issue(1); do_issue(1);
    look(1); chk("cnt2_not_blocked", issue_blocked, 0);
    cfg_rca_sel = 1; #1;
`ifdef RCA_CFG_SHADOW_EN
    chk("cfg_ready_inflight", cfg_ready, 1);
`else
    chk("cfg_ready_inflight", cfg_ready, 0);
`endif
    cfg_rca_sel = 0;
    issue_valid = 1; issue_rca_sel = 1; done_valid = 1; done_rca_sel = 1;
    cyc();
    issue_valid = 0; done_valid = 0;
    do_issue(1);
    look(1); chk("cnt3_not_blocked", issue_blocked, 0);
    do_issue(1);
    look(1); chk("cnt4_blocked", issue_blocked, 1);
    look(0); chk("cnt4_other_free", issue_blocked, 0);
    repeat (5) do_done(1);
    look(1); chk("drained_free", issue_blocked, 0);
    repeat (3) do_issue(1);
    look(1); chk("sat0_cnt3", issue_blocked, 0);
    do_issue(1);
    look(1); chk("sat0_cnt4", issue_blocked, 1);
    repeat (4) do_done(1);
    look(1); chk("drained_again", issue_blocked, 0);

    // out-of-range config and activation
    do_cfg(2, 1, 6, 31);
    chk("err_dest_port6", cfg_err, 1);
    cyc();
    chk("err_pulse_end", cfg_err, 0);
    do_cfg(2, 1, 2, 30);
    chk("err_dest_port2", cfg_err, 1);
    do_cfg(2, 0, 5, 29);
    chk("err_src_port5", cfg_err, 1);
    do_cfg(3, 0, 0, 28);
    chk("err_rca3", cfg_err, 1);
    do_act(3);
    chk("err_act3", cfg_err, 1);
    chk("act3_no_done", act_done, 0);
    chk("act3_idle", act_ready, 1);
    cyc();
    chk("err_act3_end", cfg_err, 0);

`ifdef RCA_CFG_SHADOW_EN
    // shadow write hidden until swap; activation with nothing in flight
    do_cfg(1, 0, 3, 17);
    chk("cfg_ok_no_err", cfg_err, 0);
    look(1); chk("shadow_hidden", issue_src_addrs, 0);
    do_act(1);
    chk("drain_act_ready", act_ready, 0);
    chk("drain_no_done", act_done, 0);
    look(1); chk("drain_blocked", issue_blocked, 1);
    look(0); chk("drain_other_free", issue_blocked, 0);
    cyc();
    chk("swap_done", act_done, 1);
    chk("swap_cfg_ready", cfg_ready, 0);
    look(1); chk("swap_not_yet", issue_src_addrs, 0);
    cfg_valid = 1; cfg_rca_sel = 0; cfg_src_dest = 0; cfg_port_sel = 0; cfg_reg_addr = 7;
    cyc();
    chk("post_swap_done_low", act_done, 0);
    chk("post_swap_idle", act_ready, 1);
    chk("post_swap_cfg_ready", cfg_ready, 1);
    look(1); chk("rca1_src", issue_src_addrs, 32'(17) << 15);
    look(0); chk("rca0_src_zero", issue_src_addrs, 0);
    cyc();
    cfg_valid = 0;
    do_act(0);
    cyc();
    cyc();
    look(0); chk("rca0_src_after_swap", issue_src_addrs, 7);

    // drain with two RCA2 uses outstanding
    do_cfg(2, 1, 1, 21);
    do_issue(2); do_issue(2);
    do_act(2);
    look(2); chk("rca2_blocked", issue_blocked, 1);
    look(0); chk("rca0_free", issue_blocked, 0);
    cyc();
    chk("drain_wait", act_done, 0);
    do_done(2);
    chk("drain_wait1", act_done, 0);
    do_done(2);
    chk("drain_sees_zero", act_done, 0);
    cyc();
    chk("swap_after_drain", act_done, 1);
    cyc();
    look(2); chk("rca2_dest", issue_dest_addrs, 32'(21) << 5);
    chk("rca2_unblocked", issue_blocked, 0);

    // issue in the activation cycle must drain; reset mid-drain
    act_valid = 1; act_rca_sel = 0; issue_valid = 1; issue_rca_sel = 0;
    cyc();
    act_valid = 0; issue_valid = 0;
    cyc();
    chk("same_cycle_issue_holds", act_done, 0);
    rst_n = 0;
    #1;
    rst_n = 1;
    cyc();
    look(0);
    chk("rst_mid_src0", issue_src_addrs, 0);
    chk("rst_mid_idle", act_ready, 1);
    chk("rst_mid_unblocked", issue_blocked, 0);
    look(1); chk("rst_mid_src1", issue_src_addrs, 0);
`else
    look(2);
    chk("err_no_write_src", issue_src_addrs, 0);
    chk("err_no_write_dest", issue_dest_addrs, 0);
    do_cfg(2, 0, 4, 3);
    chk("port4_no_err", cfg_err, 0);
    look(2); chk("port4_visible", issue_src_addrs, 32'(3) << 20);

    // write to RCA0 dest port1 stalled by one in-flight use
    do_issue(0);
    cfg_valid = 1; cfg_rca_sel = 0; cfg_src_dest = 1; cfg_port_sel = 1; cfg_reg_addr = 9;
    #1;
    chk("stall_ready", cfg_ready, 0);
    cyc();
    look(0);
    chk("stall_dest", issue_dest_addrs, 0);
    chk("stall_ready2", cfg_ready, 0);
    done_valid = 1; done_rca_sel = 0;
    cyc();
    done_valid = 0;
    #1;
    chk("unstall_ready", cfg_ready, 1);
    chk("unstall_dest_pending", issue_dest_addrs, 0);
    cyc();
    cfg_valid = 0;
    #1;
    chk("rca0_dest", issue_dest_addrs, 32'(9) << 5);

    do_cfg(1, 0, 3, 17);
    look(1); chk("rca1_src", issue_src_addrs, 32'(17) << 15);
    look(0); chk("rca0_src_zero", issue_src_addrs, 0);

    do_act(2);
    chk("act_done_pulse", act_done, 1);
    chk("act_no_err", cfg_err, 0);
    cyc();
    chk("act_done_end", act_done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rca_config_table.md
# rca_config_table

Per-accelerator register-mapping table for the RCA issue path. Holds, for each of `NUM_RCAS` accelerators, the source and destination register addresses of every RCA read and write port. RCA config instructions write a shadow bank; an activation handshake drains in-flight RCA use instructions and then atomically swaps the shadow map into the active map read by issue. Sits between decode/issue (lookup, in-flight tracking) and the RCA unit (completion).

## Interface
- `NUM_RCAS`, 3: number of accelerators.
- `NUM_READ_PORTS`, 5: source ports per RCA.
- `NUM_WRITE_PORTS`, 2: destination ports per RCA.
- `MAX_INFLIGHT`, 4: max outstanding use instructions per RCA.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write accepted when high with `cfg_valid`.
- `cfg_rca_sel`  in  clog2(NUM_RCAS)  target RCA.
- `cfg_src_dest`  in  1  0 = source port table, 1 = destination port table.
- `cfg_port_sel`  in  clog2(max(NUM_READ_PORTS,NUM_WRITE_PORTS))  port index.
- `cfg_reg_addr`  in  5  register address to store.
- `cfg_err`  out  1  one-cycle pulse: accepted write had out-of-range port or RCA index.
- `act_valid` / `act_ready`  in / out  1  activation request handshake.
- `act_rca_sel`  in  clog2(NUM_RCAS)  RCA to activate.
- `act_done`  out  1  one-cycle pulse in the swap cycle.
- `issue_rca_sel`  in  clog2(NUM_RCAS)  RCA being looked up by issue.
- `issue_valid`  in  1  RCA use instruction issued this cycle.
- `issue_src_addrs`  out  NUM_READ_PORTS×5  active source map of `issue_rca_sel` (combinational).
- `issue_dest_addrs`  out  NUM_WRITE_PORTS×5  active destination map (combinational).
- `issue_blocked`  out  1  issue must not fire for `issue_rca_sel`.
- `done_valid`  in  1  an RCA use instruction completed.
- `done_rca_sel`  in  clog2(NUM_RCAS)  RCA that completed.

## Operation
- Reset: active and shadow tables all zero, in-flight counters 0, FSM IDLE, `cfg_ready`=1, `act_ready`=1, `act_done`=0, `cfg_err`=0, `issue_blocked`=0.
- Config write: on `cfg_valid&&cfg_ready`, write `cfg_reg_addr` into shadow[rca][src/dest][port]; out-of-range index → no write, `cfg_err` next cycle.
- In-flight counter per RCA, width clog2(MAX_INFLIGHT+1): +1 on `issue_valid`, −1 on `done_valid`; same RCA both same cycle → unchanged. `done_valid` at 0 ignored (saturate). `issue_valid` while blocked is a protocol violation (assertion).
- `issue_blocked` = counter[issue_rca_sel]==MAX_INFLIGHT, or FSM in DRAIN/SWAP with `issue_rca_sel`==latched activation RCA.
- FSM: IDLE —(`act_valid`, `act_ready`=1 only in IDLE)→ DRAIN (latch RCA). DRAIN —(registered counter[latched]==0)→ SWAP. SWAP: copy shadow[latched] to active[latched], `act_done`=1, `cfg_ready`=0 → IDLE.
- Issue accepted in the same cycle as activation is counted and must drain first.
- Out-of-range `act_rca_sel`: accepted, FSM stays IDLE, `act_done` not pulsed, `cfg_err` pulsed.
- Reset mid-DRAIN/SWAP: returns to IDLE, all tables zero; no partial swap visible.

## Timing
- Config write at cycle T visible in shadow at T+1; never visible to issue before a swap.
- Activation accepted T with zero in-flight: DRAIN T+1, SWAP T+2 (`act_done`), new map on `issue_*_addrs` at T+3.
- Each outstanding use adds cycles until its `done_valid`; DRAIN has no timeout.
- Lookup outputs are combinational from active table; no added issue latency.

## Configuration
- `RCA_CFG_SHADOW_EN` defined: behaviour above (shadow bank + drain/swap).
- Undefined: no shadow bank or FSM; writes go directly to active; `cfg_ready`=0 while counter[`cfg_rca_sel`]≠0; `act_ready` constantly 1, `act_done` pulses the cycle after acceptance; `issue_blocked` only on counter full; write visible to issue at T+1.

## Test plan
- Reset, write shadow RCA1 src port3=5'd17, activate with nothing in flight → `act_done` at T+2, `issue_src_addrs[3]`=17 for RCA1 at T+3, RCA0 map still zero.
- Two RCA2 issues outstanding, activate RCA2 → `issue_blocked` high for RCA2, low for RCA0; SWAP one cycle after second `done_valid`.
- Issue and done same RCA same cycle at counter 2 → counter stays 2; four issues → `issue_blocked`=1 at count 4.
- `cfg_port_sel`=6 with `cfg_src_dest`=1 → no table change, `cfg_err` one-cycle pulse.
- Config write during SWAP cycle → `cfg_ready`=0, write lands the following cycle.
- Without `RCA_CFG_SHADOW_EN`: write RCA0 dest port1=5'd9 with 1 in flight → stalled until done, then visible next cycle.
